// File: rtl/hwpe_sm_params.sv
// Shared types and constants for the shared-memory address streamer.
// Provides the FSM state type, default depth and counter width helpers.
package hwpe_sm_params;

    typedef enum logic [1:0] {
        SM_IDLE  = 2'd0,
        SM_ISSUE = 2'd1,
        SM_DRAIN = 2'd2,
        SM_DONE  = 2'd3
    } sm_state_e;

    localparam int unsigned SM_MAX_OUTSTANDING = 4;
    localparam int unsigned SM_CNT_WIDTH =
        $clog2(SM_MAX_OUTSTANDING + 1);

    function automatic int unsigned sm_cnt_width(
        input int unsigned max_out
    );
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/hwpe_sm_outstanding_cnt.sv
// Up/down counter of granted-but-unanswered TCDM transactions.
// Ports: clk, rst_n, clear, inc (grant), dec (response) -> cnt, full, empty, underflow.
module hwpe_sm_outstanding_cnt
    import hwpe_sm_params::*;
#(
    parameter int unsigned MAX_OUTSTANDING = SM_MAX_OUTSTANDING,
    localparam int unsigned CNT_WIDTH = sm_cnt_width(MAX_OUTSTANDING)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 full,
    output logic                 empty,
    output logic                 underflow
);

    logic [CNT_WIDTH-1:0] cnt_q;

    assign cnt       = cnt_q;
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_WIDTH'(MAX_OUTSTANDING));
    // A response with nothing pending is an error; the count stays put.
    assign underflow = dec && empty;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_q <= '0;
        end else if (inc && !dec) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end else if (dec && !inc && !empty) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/hwpe_sm_addr_streamer.sv
// Generates one catc address per job element, drives the TCDM request
// handshake, bounds outstanding transactions and signals job completion.
// Ports: clk, rst_n, clear; start + cfg_* job setup; catc_add, tcdm_req/gnt/r_valid;
//        status busy, done, issued_cnt, wrap_flag, err.
module hwpe_sm_addr_streamer
    import hwpe_sm_params::*;
#(
    parameter int unsigned CATC_ADDR_WIDTH    = 32,
    parameter int unsigned BASE_ALIGNMENT_BIT = 6,
    parameter int unsigned N_POINTERS         = 1,
    parameter int unsigned LEN_WIDTH          = 16,
    parameter int unsigned MAX_OUTSTANDING    = SM_MAX_OUTSTANDING,
    localparam int unsigned LOG_POINTERS =
        (N_POINTERS > 1) ? $clog2(N_POINTERS) : 1,
    localparam int unsigned CNT_WIDTH = sm_cnt_width(MAX_OUTSTANDING)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          start,
    input  logic [LOG_POINTERS-1:0]       cfg_pointer,
    input  logic [BASE_ALIGNMENT_BIT-1:0] cfg_elem,
    input  logic [BASE_ALIGNMENT_BIT-1:0] cfg_stride,
    input  logic [LEN_WIDTH-1:0]          cfg_len,
    output logic [CATC_ADDR_WIDTH-1:0]    catc_add,
    output logic                          tcdm_req,
    input  logic                          tcdm_gnt,
    input  logic                          tcdm_r_valid,
    output logic                          busy,
    output logic                          done,
    output logic [LEN_WIDTH-1:0]          issued_cnt,
    output logic                          wrap_flag,
    output logic                          err
);

    localparam int unsigned FILL_W =
        CATC_ADDR_WIDTH - BASE_ALIGNMENT_BIT - LOG_POINTERS;

    sm_state_e state_q, state_d;

    logic [LOG_POINTERS-1:0]       ptr_q;
    logic [BASE_ALIGNMENT_BIT-1:0] elem_q;
    logic [BASE_ALIGNMENT_BIT-1:0] stride_q;
    logic [LEN_WIDTH-1:0]          len_q;
    logic [LEN_WIDTH-1:0]          issued_q;
    logic                          wrap_q;
    logic                          err_q;

    logic [CNT_WIDTH-1:0]          out_cnt;
    logic                          out_full;
    logic                          out_empty;
    logic                          out_underflow;

    logic                          fire;
    logic                          start_ok;
    logic                          last_req;
    logic [BASE_ALIGNMENT_BIT:0]   elem_sum;

    hwpe_sm_outstanding_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) i_out_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .inc      (fire),
        .dec      (tcdm_r_valid),
        .cnt      (out_cnt),
        .full     (out_full),
        .empty    (out_empty),
        .underflow(out_underflow)
    );

    assign tcdm_req   = (state_q == SM_ISSUE) && !out_full;
    assign fire       = tcdm_req && tcdm_gnt;
    assign start_ok   = (state_q == SM_IDLE) && start;
    assign last_req   = (issued_q == len_q - LEN_WIDTH'(1));
    // Extra MSB captures the carry-out of the element field.
    assign elem_sum   = {1'b0, elem_q} + {1'b0, stride_q};

    assign catc_add   = {{FILL_W{1'b0}}, ptr_q, elem_q};
    assign busy       = (state_q == SM_ISSUE) || (state_q == SM_DRAIN);
    assign done       = (state_q == SM_DONE);
    assign issued_cnt = issued_q;
    assign wrap_flag  = wrap_q;
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= SM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SM_IDLE: begin
                if (start) begin
                    state_d = (cfg_len != '0) ? SM_ISSUE : SM_DONE;
                end
            end
            SM_ISSUE: begin
                if (fire && last_req) begin
                    state_d = SM_DRAIN;
                end
            end
            SM_DRAIN: begin
                // Last response arriving this cycle empties the counter.
                if (out_empty ||
                    (out_cnt == CNT_WIDTH'(1) && tcdm_r_valid)) begin
                    state_d = SM_DONE;
                end
            end
            SM_DONE: begin
                state_d = SM_IDLE;
            end
            default: begin
                state_d = SM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            ptr_q    <= '0;
            elem_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            issued_q <= '0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                ptr_q    <= cfg_pointer;
                elem_q   <= cfg_elem;
                stride_q <= cfg_stride;
                len_q    <= cfg_len;
                issued_q <= '0;
                wrap_q   <= 1'b0;
            end else if (fire) begin
                elem_q   <= elem_sum[BASE_ALIGNMENT_BIT-1:0];
                issued_q <= issued_q + LEN_WIDTH'(1);
                if (elem_sum[BASE_ALIGNMENT_BIT]) begin
                    wrap_q <= 1'b1;
                end
            end
            // A stray response wins over the clear of an accepted start.
            err_q <= out_underflow || (err_q && !start_ok);
        end
    end

endmodule

// File: tb/tb_hwpe_sm_addr_streamer.sv
// Scoreboard bench for hwpe_sm_addr_streamer.
// Random and directed jobs checked against an arithmetic address model.
module tb_hwpe_sm_addr_streamer;

    localparam int AW   = 32;
    localparam int BAB  = 6;
    localparam int LP   = 1;
    localparam int LW   = 16;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          start;
    logic [LP-1:0] cfg_pointer;
    logic [BAB-1:0] cfg_elem;
    logic [BAB-1:0] cfg_stride;
    logic [LW-1:0] cfg_len;
    logic [AW-1:0] catc_add;
    logic          tcdm_req;
    logic          tcdm_gnt;
    logic          tcdm_r_valid;
    logic          busy;
    logic          done;
    logic [LW-1:0] issued_cnt;
    logic          wrap_flag;
    logic          err;

    hwpe_sm_addr_streamer #(
        .CATC_ADDR_WIDTH(AW),
        .BASE_ALIGNMENT_BIT(BAB),
        .N_POINTERS(1),
        .LEN_WIDTH(LW),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .start       (start),
        .cfg_pointer (cfg_pointer),
        .cfg_elem    (cfg_elem),
        .cfg_stride  (cfg_stride),
        .cfg_len     (cfg_len),
        .catc_add    (catc_add),
        .tcdm_req    (tcdm_req),
        .tcdm_gnt    (tcdm_gnt),
        .tcdm_r_valid(tcdm_r_valid),
        .busy        (busy),
        .done        (done),
        .issued_cnt  (issued_cnt),
        .wrap_flag   (wrap_flag),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LW-1:0] issued;
        logic          wrap;
        logic          err;
    } job_t;

    logic [AW-1:0] exp_addr[$];
    job_t          exp_job[$];

    int n_chk = 0;
    int n_fail = 0;
    int model_out = 0;
    int job_fires = 0;
    int done_cnt = 0;
    bit accepted = 1'b0;
    int gnt_mode = 0;
    int stall_left = 0;
    int resp_mode = 0;
    int resp_budget = 0;
    bit stray = 1'b0;
    bit hold_v = 1'b0;
    logic [AW-1:0] hold_a;

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Memory side: grant policy and responses for pending transactions.
    always @(posedge clk) begin
        #1;
        case (gnt_mode)
            0: tcdm_gnt = 1'b1;
            1: tcdm_gnt = 1'($urandom_range(0, 1));
            default: begin
                if (job_fires == 2 && stall_left > 0 && tcdm_req) begin
                    tcdm_gnt = 1'b0;
                    stall_left--;
                end else begin
                    tcdm_gnt = 1'b1;
                end
            end
        endcase
        if (stray) begin
            tcdm_r_valid = 1'b1;
            stray = 1'b0;
        end else if (model_out > 0) begin
            case (resp_mode)
                0: tcdm_r_valid = 1'b1;
                1: begin
                    if (resp_budget > 0) begin
                        tcdm_r_valid = 1'b1;
                        resp_budget--;
                    end else begin
                        tcdm_r_valid = 1'b0;
                    end
                end
                default: tcdm_r_valid = 1'($urandom_range(0, 1));
            endcase
        end else begin
            tcdm_r_valid = 1'b0;
        end
    end

    // Monitor: compares everything the DUT presents against the model.
    always @(negedge clk) begin
        if (!rst_n || clear) begin
            exp_addr.delete();
            exp_job.delete();
            model_out = 0;
            hold_v = 1'b0;
            job_fires = 0;
        end else begin
            if (hold_v) begin
                check("hold_req", 64'(tcdm_req), 64'd1);
                check("hold_addr", 64'(catc_add), 64'(hold_a));
            end
            hold_v = tcdm_req && !tcdm_gnt;
            hold_a = catc_add;
            if (!accepted) begin
                check("req_gate", 64'(tcdm_req),
                      64'(exp_addr.size() > 0 && model_out < MAXO));
            end
            if (tcdm_req && tcdm_gnt) begin
                if (exp_addr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL grant: unexpected grant addr %0h, expected none",
                             catc_add);
                end else begin
                    check("addr", 64'(catc_add), 64'(exp_addr.pop_front()));
                end
                model_out++;
                job_fires++;
            end
            if (tcdm_r_valid && model_out > 0) model_out--;
            if (done) begin
                if (exp_job.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done: unexpected done pulse, expected none");
                end else begin
                    job_t j;
                    j = exp_job.pop_front();
                    check("issued_cnt", 64'(issued_cnt), 64'(j.issued));
                    check("wrap_flag", 64'(wrap_flag), 64'(j.wrap));
                    check("err", 64'(err), 64'(j.err));
                    check("drained", 64'(model_out), 64'd0);
                    check("addr_left", 64'(exp_addr.size()), 64'd0);
                end
                done_cnt++;
            end
        end
    end

    task automatic start_job(int ptr, int elem, int stride, int len);
        job_t j;
        @(posedge clk);
        #2;
        cfg_pointer = LP'(ptr);
        cfg_elem    = BAB'(elem);
        cfg_stride  = BAB'(stride);
        cfg_len     = LW'(len);
        start       = 1'b1;
        accepted    = 1'b1;
        job_fires   = 0;
        for (int k = 0; k < len; k++) begin
            exp_addr.push_back(AW'((ptr << BAB) | ((elem + k * stride) % 64)));
        end
        j.issued = LW'(len);
        j.wrap   = ((elem + len * stride) >= 64);
        j.err    = 1'b0;
        exp_job.push_back(j);
        @(posedge clk);
        #2;
        start    = 1'b0;
        accepted = 1'b0;
    endtask

    task automatic ignored_start();
        @(posedge clk);
        #2;
        cfg_pointer = LP'($urandom_range(0, 1));
        cfg_elem    = BAB'($urandom);
        cfg_stride  = BAB'($urandom);
        cfg_len     = LW'($urandom_range(1, 3));
        start       = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int target;
        int cyc;
        target = done_cnt + 1;
        cyc = 0;
        while (done_cnt < target && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        if (done_cnt < target) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles, expected one",
                     cyc);
        end
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        start = 1'b0;
        cfg_pointer = '0;
        cfg_elem = '0;
        cfg_stride = '0;
        cfg_len = '0;
        tcdm_gnt = 1'b0;
        tcdm_r_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_catc_add", 64'(catc_add), 64'd0);
        check("rst_req", 64'(tcdm_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_issued", 64'(issued_cnt), 64'd0);
        check("rst_wrap", 64'(wrap_flag), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Basic job and element-field wrap.
        start_job(0, 2, 1, 4);
        wait_done();
        start_job(0, 60, 3, 3);
        wait_done();

        // Backpressure on request 2, plus a start that must be ignored.
        gnt_mode = 2;
        stall_left = 5;
        start_job(1, 10, 5, 8);
        ignored_start();
        wait_done();
        gnt_mode = 0;

        // Outstanding limit with withheld responses.
        resp_mode = 1;
        resp_budget = 0;
        start_job(0, 0, 1, 8);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("limit_req", 64'(tcdm_req), 64'd0);
        check("limit_issued", 64'(issued_cnt), 64'd4);
        resp_budget = 1;
        repeat (3) @(posedge clk);
        resp_mode = 0;
        wait_done();

        // Zero-length job and a stray response in IDLE.
        start_job(0, 5, 1, 0);
        @(negedge clk);
        check("len0_done", 64'(done), 64'd1);
        @(posedge clk);
        #2;
        stray = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stray_err", 64'(err), 64'd1);
        check("stray_busy", 64'(busy), 64'd0);

        // Mid-job clear, then a clean job.
        start_job(0, 1, 2, 10);
        for (int c = 0; c < 100 && job_fires < 2; c++) @(posedge clk);
        @(posedge clk);
        #2;
        clear = 1'b1;
        @(posedge clk);
        #2;
        clear = 1'b0;
        @(negedge clk);
        check("clear_req", 64'(tcdm_req), 64'd0);
        check("clear_busy", 64'(busy), 64'd0);
        check("clear_issued", 64'(issued_cnt), 64'd0);
        start_job(0, 7, 9, 2);
        wait_done();

        // Randomised jobs with random grants and responses.
        gnt_mode = 1;
        resp_mode = 2;
        for (int n = 0; n < 12; n++) begin
            start_job(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                      int'($urandom_range(0, 63)), int'($urandom_range(1, 20)));
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_sm_addr_streamer.md
Name: hwpe_sm_addr_streamer

Overview:
Sequencer that produces the stream of accelerator-side (catc) addresses fed to the shared-memory address translation stage, one per element of a programmed job. It drives the TCDM request handshake, bounds the number of outstanding transactions and counts responses. It signals completion only once every response has returned. It sits between the HWPE control/register-file logic and the translation + TCDM port of the shared-memory wrapper.

Parameters:
CATC_ADDR_WIDTH, 32, width of the generated catc address
BASE_ALIGNMENT_BIT, 6, width of the element field inside a catc address
N_POINTERS, 1, number of selectable base pointers (LOG_POINTERS = $clog2(N_POINTERS), min 1 bit)
LEN_WIDTH, 16, width of the job length and element counters
MAX_OUTSTANDING, 4, max granted-but-unanswered requests (power of 2, >=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clear  in  1  synchronous soft clear, same effect as reset
start  in  1  job start pulse; sampled only in IDLE
cfg_pointer  in  LOG_POINTERS  base-pointer index for the job
cfg_elem  in  BASE_ALIGNMENT_BIT  first element offset
cfg_stride  in  BASE_ALIGNMENT_BIT  element increment per request
cfg_len  in  LEN_WIDTH  number of requests in the job
catc_add  out  CATC_ADDR_WIDTH  address to translation stage
tcdm_req  out  1  request valid
tcdm_gnt  in  1  request grant
tcdm_r_valid  in  1  response valid, one per granted request
busy  out  1  high from ISSUE through DRAIN
done  out  1  one-cycle completion pulse
issued_cnt  out  LEN_WIDTH  requests granted in the current job
wrap_flag  out  1  sticky: element field wrapped in this job
err  out  1  sticky: response received with zero outstanding

Behaviour:
- Reset/clear values: state IDLE; catc_add=0, tcdm_req=0, busy=0, done=0, issued_cnt=0, wrap_flag=0, err=0; outstanding counter=0.
- catc_add = {zero-fill, ptr_q, elem_q}. ptr_q occupies bits [BASE_ALIGNMENT_BIT+LOG_POINTERS-1:BASE_ALIGNMENT_BIT]; elem_q occupies the low BASE_ALIGNMENT_BIT bits.
- All cfg_* inputs are registered on an accepted start and are ignored afterwards.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 and cfg_len!=0 -> ISSUE. In the same edge, latch config, elem_q=cfg_elem, issued_cnt=0, and clear wrap_flag and err. start=1 and cfg_len==0 -> DONE, with no request issued. start in any other state is ignored.
- ISSUE: tcdm_req = (outstanding < MAX_OUTSTANDING). First req is asserted in the cycle after start (latency 1).
- On tcdm_req & tcdm_gnt: elem_q += cfg_stride, modulo 2^BASE_ALIGNMENT_BIT. A carry-out sets wrap_flag. issued_cnt and outstanding each increment by 1.
- When the last request (issued_cnt == len-1) is granted -> DRAIN.
- catc_add is held stable while tcdm_req=1 and tcdm_gnt=0. The request is never retracted.
- Back-to-back grants are allowed: one request per cycle.
- outstanding: +1 on grant, -1 on tcdm_r_valid. Both in the same cycle -> unchanged. Counter width is $clog2(MAX_OUTSTANDING+1).
- At outstanding == MAX_OUTSTANDING, tcdm_req drops in that cycle. It is reasserted in the cycle after any r_valid.
- tcdm_r_valid with outstanding==0 (any state): counter stays at 0 and err is set.
- DRAIN: tcdm_req=0. Move to DONE when outstanding==0, or when outstanding==1 and tcdm_r_valid=1.
- DONE: done=1 for exactly one cycle -> IDLE. issued_cnt, wrap_flag and err hold until the next accepted start.
- busy=1 in ISSUE and DRAIN only.
- clear or rst_n=0 mid-job: immediate return to IDLE, all state zeroed, tcdm_req low in the next cycle. The requester must only clear when the TCDM side is quiescent; any stray r_valid that follows sets err.

Decomposition:
- hwpe_sm_params gets:
  - streamer state enum type;
  - default MAX_OUTSTANDING constant;
  - helper localparam for counter width.
- One sub-module, hwpe_sm_outstanding_cnt: up/down counter with full/empty outputs and an underflow error output, parameterised by MAX_OUTSTANDING.
- The FSM and address generation stay in the top module.

Test Plan:
1. Basic job: pointer=0, elem=2, stride=1, len=4, gnt tied 1, r_valid one cycle after grant -> catc_add 0x02,0x03,0x04,0x05 on consecutive cycles starting 1 cycle after start; done pulse after 4th response; issued_cnt=4; wrap_flag=0.
2. Wrap: elem=60, stride=3, len=3, BASE_ALIGNMENT_BIT=6 -> addresses 60, 63, 2; wrap_flag=1 at done.
3. Backpressure: len=8, gnt=0 for 5 cycles on request 2 -> catc_add stable for those cycles; all 8 addresses issued exactly once, in order.
4. Outstanding limit: MAX_OUTSTANDING=4, gnt=1, responses withheld -> exactly 4 grants then req=0. One r_valid -> req reasserts next cycle. Simultaneous gnt+r_valid keeps the count at 4.
5. Edge cases:
   - len=0 -> no req; done one cycle later.
   - start during busy -> ignored; issued_cnt continues unchanged.
   - r_valid in IDLE -> err=1.
6. Mid-job clear after 2 grants -> req=0 and busy=0 in the next cycle; a subsequent start with len=2 runs cleanly with err=0.
